// File: rtl/main_mem_arbiter.sv
// Arbitrates icache refills and dcache refills/writebacks onto one main-memory port.
// One transaction in flight at a time; icache refills can be squashed by a frontend flush.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ICACHE_DATA_BLOCK_SIZE
`define ICACHE_DATA_BLOCK_SIZE 64
`endif

// state  | meaning
// IDLE   | no transaction; ready offered to the arbitration winner
// REQ    | mem_req_valid high, waiting for mem_req_ready
// WAIT   | request accepted, waiting for mem_resp_valid
// RESP   | one-cycle response pulse to the owner
module main_mem_arbiter #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int BLOCK_SIZE = `ICACHE_DATA_BLOCK_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_aL,
  input  logic                  ic_req_valid,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  output logic                  ic_req_ready,
  input  logic                  ic_flush,
  input  logic                  dc_req_valid,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr,
  input  logic                  dc_req_is_st,
  input  logic [BLOCK_SIZE-1:0] dc_req_wdata,
  output logic                  dc_req_ready,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_we,
  output logic [BLOCK_SIZE-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [BLOCK_SIZE-1:0] mem_resp_data,
  output logic                  ic_resp_valid,
  output logic [ADDR_WIDTH-1:0] ic_resp_addr,
  output logic [BLOCK_SIZE-1:0] ic_resp_data,
  output logic                  dc_resp_valid,
  output logic [BLOCK_SIZE-1:0] dc_resp_data,
  output logic                  busy
);

  localparam int OFFSET = $clog2(BLOCK_SIZE / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET;
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  squash_q, squash_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0] rdata_q, rdata_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  busy_q, busy_d;
  logic                  ic_resp_valid_q, ic_resp_valid_d;
  logic                  dc_resp_valid_q, dc_resp_valid_d;
  logic                  ic_cand, grant_ic, grant_dc, squash_now;

  // A flushing frontend cannot start a new refill, so the icache is not a candidate that cycle.
  always_comb begin
    ic_cand  = ic_req_valid & ~ic_flush;
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state_q == S_IDLE) begin
      if (ic_cand && dc_req_valid) begin
        grant_ic = (last_grant_q == OWN_DC);
        grant_dc = (last_grant_q == OWN_IC);
      end else begin
        grant_ic = ic_cand;
        grant_dc = dc_req_valid;
      end
    end
  end

  assign ic_req_ready = grant_ic;
  assign dc_req_ready = grant_dc;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    squash_d        = squash_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    ic_resp_valid_d = 1'b0;
    dc_resp_valid_d = 1'b0;
    squash_now      = squash_q | (ic_flush & (owner_q == OWN_IC));

    case (state_q)
      S_IDLE: begin
        if (grant_ic) begin
          owner_d      = OWN_IC;
          last_grant_d = OWN_IC;
          addr_d       = ic_req_addr & ADDR_MASK;
          we_d         = 1'b0;
          wdata_d      = '0;
          squash_d     = 1'b0;
          state_d      = S_REQ;
        end else if (grant_dc) begin
          owner_d      = OWN_DC;
          last_grant_d = OWN_DC;
          addr_d       = dc_req_addr & ADDR_MASK;
          we_d         = dc_req_is_st;
          wdata_d      = dc_req_wdata;
          squash_d     = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        squash_d = squash_now;
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        squash_d = squash_now;
        if (mem_resp_valid) begin
          rdata_d         = mem_resp_data;
          ic_resp_valid_d = (owner_q == OWN_IC) & ~squash_now;
          dc_resp_valid_d = (owner_q == OWN_DC);
          state_d         = S_RESP;
        end
      end
      S_RESP: begin
        squash_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_valid_d = (state_d == S_REQ);
    busy_d          = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q         <= S_IDLE;
      owner_q         <= OWN_IC;
      last_grant_q    <= OWN_DC;
      squash_q        <= 1'b0;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      mem_req_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      squash_q        <= squash_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      busy_q          <= busy_d;
      ic_resp_valid_q <= ic_resp_valid_d;
      dc_resp_valid_q <= dc_resp_valid_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign ic_resp_valid = ic_resp_valid_q;
  assign ic_resp_addr  = addr_q;
  assign ic_resp_data  = rdata_q;
  assign dc_resp_valid = dc_resp_valid_q;
  assign dc_resp_data  = rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: arbitration, store path, stalls, flush squash, reset abandon.
module tb_main_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_aL = 1'b0;
  logic        ic_req_valid, ic_req_ready, ic_flush;
  logic [31:0] ic_req_addr;
  logic        dc_req_valid, dc_req_is_st, dc_req_ready;
  logic [31:0] dc_req_addr;
  logic [63:0] dc_req_wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        ic_resp_valid, dc_resp_valid, busy;
  logic [31:0] ic_resp_addr;
  logic [63:0] ic_resp_data, dc_resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  main_mem_arbiter dut (
    .clk(clk), .rst_aL(rst_aL),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_flush(ic_flush),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_is_st(dc_req_is_st),
    .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .ic_resp_valid(ic_resp_valid), .ic_resp_addr(ic_resp_addr), .ic_resp_data(ic_resp_data),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered in a REQ cycle; leaves the DUT in its RESP cycle.
  task automatic serve(input logic [31:0] exp_addr, input int n_stall, input int n_wait,
                       input logic flush, input logic [63:0] data);
    for (int i = 0; i < n_stall; i++) begin
      check("stall_valid", mem_req_valid, 1);
      check("stall_addr", mem_req_addr, exp_addr);
      check("stall_busy", busy, 1);
      tick;
    end
    check("req_valid", mem_req_valid, 1);
    check("req_addr", mem_req_addr, exp_addr);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    check("wait_req_low", mem_req_valid, 0);
    ic_flush = flush;
    for (int i = 0; i < n_wait; i++) tick;
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    tick;
    mem_resp_valid = 1'b0;
    ic_flush       = 1'b0;
  endtask

  initial begin
    ic_req_valid = 0; ic_req_addr = '0; ic_flush = 0;
    dc_req_valid = 0; dc_req_addr = '0; dc_req_is_st = 0; dc_req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;

    #2;
    check("rst_busy", busy, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_we", mem_req_we, 0);
    check("rst_addr", mem_req_addr, 0);
    check("rst_ic_resp", ic_resp_valid, 0);
    check("rst_dc_resp", dc_resp_valid, 0);
    #10 rst_aL = 1'b1;
    tick;

    // Tie right after reset: icache first, then dcache
    ic_req_valid = 1; ic_req_addr = 32'h0000_1004;
    dc_req_valid = 1; dc_req_addr = 32'h0000_4000; dc_req_is_st = 0;
    #1;
    check("tie1_ic_ready", ic_req_ready, 1);
    check("tie1_dc_ready", dc_req_ready, 0);
    tick;
    ic_req_valid = 0;
    #1;
    check("ic_req_busy", busy, 1);
    check("ic_req_we", mem_req_we, 0);
    check("busy_dc_ready", dc_req_ready, 0);
    serve(32'h0000_1000, 0, 1, 0, 64'hDEAD_BEEF_0000_0013);
    check("ic_resp_valid", ic_resp_valid, 1);
    check("ic_resp_addr", ic_resp_addr, 32'h0000_1000);
    check("ic_resp_data", ic_resp_data, 64'hDEAD_BEEF_0000_0013);
    check("ic_resp_dc_quiet", dc_resp_valid, 0);
    tick;
    check("ic_resp_pulse", ic_resp_valid, 0);
    check("idle_busy", busy, 0);

    ic_req_valid = 1; ic_req_addr = 32'h0000_1040;
    #1;
    check("tie2_dc_ready", dc_req_ready, 1);
    check("tie2_ic_ready", ic_req_ready, 0);
    tick;
    ic_req_valid = 0; dc_req_valid = 0;
    serve(32'h0000_4000, 5, 0, 0, 64'hA5A5_5A5A_0F0F_F0F0);
    check("dc_resp_valid", dc_resp_valid, 1);
    check("dc_resp_data", dc_resp_data, 64'hA5A5_5A5A_0F0F_F0F0);
    check("dc_resp_ic_quiet", ic_resp_valid, 0);
    tick;
    check("dc_resp_pulse", dc_resp_valid, 0);

    // dcache store
    dc_req_valid = 1; dc_req_addr = 32'h0000_2008; dc_req_is_st = 1;
    dc_req_wdata = 64'h1122_3344_5566_7788;
    #1;
    check("st_ready", dc_req_ready, 1);
    tick;
    dc_req_valid = 0; dc_req_is_st = 0;
    check("st_we", mem_req_we, 1);
    check("st_wdata", mem_req_wdata, 64'h1122_3344_5566_7788);
    serve(32'h0000_2008, 0, 2, 0, 64'h0);
    check("st_ack", dc_resp_valid, 1);
    tick;
    check("st_ack_pulse", dc_resp_valid, 0);
    check("st_idle_valid", mem_req_valid, 0);

    // Flush blocks icache acceptance; dcache wins and is unaffected by flush
    ic_req_valid = 1; ic_req_addr = 32'h0000_5000; ic_flush = 1;
    dc_req_valid = 1; dc_req_addr = 32'h0000_6010;
    #1;
    check("flush_ic_ready", ic_req_ready, 0);
    check("flush_dc_ready", dc_req_ready, 1);
    tick;
    ic_flush = 0; ic_req_valid = 0; dc_req_valid = 0;
    serve(32'h0000_6010, 0, 1, 1, 64'h0123_4567_89AB_CDEF);
    check("flush_dc_resp", dc_resp_valid, 1);
    check("flush_dc_data", dc_resp_data, 64'h0123_4567_89AB_CDEF);
    tick;

    // Flush during WAIT squashes the icache refill
    ic_req_valid = 1; ic_req_addr = 32'h0000_3008;
    #1;
    check("sq_ic_ready", ic_req_ready, 1);
    tick;
    ic_req_valid = 0;
    serve(32'h0000_3008, 0, 1, 1, 64'hFFFF_0000_FFFF_0000);
    check("sq_resp_valid", ic_resp_valid, 0);
    check("sq_resp_busy", busy, 1);
    tick;
    check("sq_idle", busy, 0);
    check("sq_after_pulse", ic_resp_valid, 0);

    ic_req_valid = 1; ic_req_addr = 32'h0000_3010;
    #1;
    check("post_sq_ready", ic_req_ready, 1);
    tick;
    ic_req_valid = 0;
    serve(32'h0000_3010, 0, 0, 0, 64'h0000_0000_0000_0055);
    check("post_sq_valid", ic_resp_valid, 1);
    check("post_sq_addr", ic_resp_addr, 32'h0000_3010);
    check("post_sq_data", ic_resp_data, 64'h55);
    tick;

    // Reset during WAIT abandons the transaction
    ic_req_valid = 1; ic_req_addr = 32'h0000_7000;
    tick;
    ic_req_valid = 0;
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0;
    check("rw_busy", busy, 1);
    rst_aL = 0;
    #1;
    check("rw_busy_rst", busy, 0);
    check("rw_valid_rst", mem_req_valid, 0);
    check("rw_addr_rst", mem_req_addr, 0);
    check("rw_ic_resp_rst", ic_resp_valid, 0);
    tick;
    rst_aL = 1;
    tick;
    mem_resp_valid = 1; mem_resp_data = 64'hCAFE_F00D_CAFE_F00D;
    tick;
    mem_resp_valid = 0;
    check("rw_late_ic", ic_resp_valid, 0);
    check("rw_late_dc", dc_resp_valid, 0);
    check("rw_late_busy", busy, 0);
    tick;
    check("rw_late_ic2", ic_resp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
